mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Two-requester arbiter and sequencer for the shared 32x32 signed multiplier `MULT`. It accepts operand pairs from two independent clients over valid/ready handshakes and grants them round-robin. It holds the granted operands stable on the multiplier for its fixed latency, then returns the 64-bit product with the requester ID over a valid/ready response channel. It owns the only `MULT` instance in the arithmetic subsystem.

## Interface
- `MULT_LAT`, default 1: `MULT` latency in cycles from operands stable to `z` valid. 0 means combinational; allowed range is 0–15.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0 pair accepted this cycle.
- `req0_a` in 32: requester 0 operand A, signed.
- `req0_b` in 32: requester 0 operand B, signed.
- `req1_valid` in 1: requester 1 has an operand pair.
- `req1_ready` out 1: requester 1 pair accepted this cycle.
- `req1_a` in 32: requester 1 operand A, signed.
- `req1_b` in 32: requester 1 operand B, signed.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: consumer takes the product.
- `rsp_z` out 64: signed product A*B.
- `rsp_id` out 1: requester that issued the product.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP (encoded 2'b00, 2'b01, 2'b10).
- **IDLE**
  - If any `reqN_valid` is high, pick one grant.
    - Only one valid: grant that requester.
    - Both valid: grant the requester not granted last (`last_id` pointer).
  - `reqN_ready` is combinational: `(state==IDLE) & grant_N`. At most one ready is high per cycle.
  - On a handshake edge, register A, B and the ID. Load `cnt <= MULT_LAT`. Go to WAIT.
- **WAIT**
  - Registered operands drive `MULT.a`/`MULT.b` unchanged for the whole state.
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: register `rsp_z <= MULT.z`, set `rsp_valid <= 1`, go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_z` and `rsp_id` stable until `rsp_ready`.
  - On the handshake edge: `rsp_valid <= 0`, `last_id <= rsp_id`, go to IDLE.
- Requests arriving outside IDLE are not lost. Clients must hold valid and data until ready, per the standard valid/ready rules.
- One operation is in flight at a time. There is no pipelining across requests.
- Arithmetic:
  - Two's-complement signed, 32x32 to full 64 bits. No truncation or saturation.
  - `rsp_z` is exactly `MULT.z`; the controller does no arithmetic.

## Timing
- Reset asserted (low), asynchronous:
  - state IDLE, `cnt=0`
  - `last_id=1`, so requester 0 wins the first tie
  - `rsp_valid=0`, `rsp_z=0`, `rsp_id=0`, `busy=0`
  - both readys 0 while reset is low
- `MULT.reset` is driven from the same `reset` net.
- Reset mid-operation aborts: the in-flight product is discarded, no response is emitted, and arbitration restarts from reset state.
- Accept edge E0: `rsp_valid` rises after edge E0+MULT_LAT+1.
  - With `rsp_ready` held high, the next IDLE is after E0+MULT_LAT+2.
  - The earliest next accept is at edge E0+MULT_LAT+3.
  - Peak throughput is one product per MULT_LAT+3 cycles.
- `rsp_ready` high in the same cycle `rsp_valid` rises completes the handshake at that cycle's edge.
- A new `reqN_valid` in the cycle of the RESP handshake is not accepted. It waits one cycle for IDLE.
- Withdrawn valid (protocol violation) is unsupported; no recovery is required.
- `cnt` width is 4 bits; no wrap occurs for `MULT_LAT` ≤ 15.

## Structure
- Package `mult_arb_pkg`:
  - state typedef/localparams IDLE/WAIT/RESP
  - `OP_W=32`, `PROD_W=64`, `CNT_W=4`
- One sub-module: the existing `MULT` (ports `clk`, `reset`, `a`, `b`, `z`), instantiated once inside `mult_arbiter`.
- Arbitration logic stays inline; it is a 1-bit pointer and needs no separate module.

## Test plan
- Reset mid-WAIT:
  - Stimulus: accept a request, pull `reset` low during WAIT, release.
  - Response: no `rsp_valid`; `busy=0`; on a simultaneous request next, requester 0 is granted.
- Single request, negative operands:
  - Stimulus: req0 A=B=0xFFFFFFFB (−5).
  - Response: `rsp_z=0x0000_0000_0000_0019`, `rsp_id=0`, `rsp_valid` exactly MULT_LAT+1 cycles after accept.
- Mixed sign:
  - Stimulus: req1 A=0xFFFFFFFB, B=5.
  - Response: `rsp_z=0xFFFF_FFFF_FFFF_FFE7`, `rsp_id=1`.
- Contention:
  - Stimulus: both valid continuously; req0 10×5, req1 −5×−5; `rsp_ready=1`.
  - Response: responses alternate id 0 (50 = 0x32), id 1 (25), id 0, ...; never two consecutive grants to one requester.
- Backpressure:
  - Stimulus: `rsp_ready=0` for 10 cycles after `rsp_valid`.
  - Response: `rsp_z`/`rsp_id` stable, both readys 0, `busy=1`; after `rsp_ready` pulse, IDLE next cycle.
- Extremes:
  - 0x80000000 × 0x80000000 → `0x4000_0000_0000_0000`.
  - 0x7FFFFFFF × 0x80000000 → `0xC000_0000_8000_0000`.
  - Repeat both with MULT_LAT=0 and MULT_LAT=3.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter and its MULT instance.
package mult_arb_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/mult_arbiter_mult.sv
// Signed 32x32 multiplier with LAT pipeline stages on the product (LAT=0 is combinational).
module MULT
    import mult_arb_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] z
);

    logic [PROD_W-1:0] prod;

    assign prod = PROD_W'($signed(a)) * PROD_W'($signed(b));

    generate
        if (LAT == 0) begin : g_comb
            assign z = prod;
        end else begin : g_pipe
            logic [PROD_W-1:0] pipe_q [LAT];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= prod;
                    for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign z = pipe_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding two requesters into the single shared MULT instance.
//   state | meaning
//   IDLE  | waiting for a request; grants one requester
//   WAIT  | operands held on MULT, counting down its latency
//   RESP  | product held on the response channel until taken
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned MULT_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_z,
    output logic              rsp_id,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_id_q, last_id_d;
    logic              id_q, id_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [PROD_W-1:0] rsp_z_q, rsp_z_d;
    logic              rsp_id_q, rsp_id_d;
    logic              grant0, grant1;
    logic [PROD_W-1:0] mult_z;

    // On a tie the requester that was not served last wins.
    assign grant0 = req0_valid & (~req1_valid | last_id_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_id_q);

    assign req0_ready = reset & (state_q == IDLE) & grant0;
    assign req1_ready = reset & (state_q == IDLE) & grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_id_d   = last_id_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(MULT_LAT);
                    id_d    = grant1;
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_z_d     = mult_z;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_id_d   = rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_id_q   <= 1'b1;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    MULT #(.LAT(MULT_LAT)) u_mult (
        .clk   (clk),
        .reset (reset),
        .a     (a_q),
        .b     (b_q),
        .z     (mult_z)
    );

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: three instances (MULT_LAT = 1, 0, 3) with a shared reset.
module tb_mult_arbiter;

    typedef struct {
        logic [63:0] z;
        logic        id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]  rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] req0_a [3];
    logic [31:0] req0_b [3];
    logic [31:0] req1_a [3];
    logic [31:0] req1_b [3];
    logic [63:0] rsp_z  [3];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mult_arbiter #(.MULT_LAT(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req0_valid (req0_valid[g]),
            .req0_ready (req0_ready[g]),
            .req0_a     (req0_a[g]),
            .req0_b     (req0_b[g]),
            .req1_valid (req1_valid[g]),
            .req1_ready (req1_ready[g]),
            .req1_a     (req1_a[g]),
            .req1_b     (req1_b[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_z      (rsp_z[g]),
            .rsp_id     (rsp_id[g]),
            .busy       (busy[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input int k, input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_z"}, rsp_z[k], e.z);
            chk({tag, "_id"}, rsp_id[k], e.id);
        end
    endtask

    task automatic drive_req(input int k, input bit id, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid[k] = 1'b1; req1_a[k] = a; req1_b[k] = b;
        end else begin
            req0_valid[k] = 1'b1; req0_a[k] = a; req0_b[k] = b;
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge.
    task automatic accept(input int k, input bit id, input string tag, output int e0);
        int n = 0;
        #1;
        while (!(id ? req1_ready[k] : req0_ready[k]) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_accept_timeout"}, 64'(n < 20), 1);
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        if (id) req1_valid[k] = 1'b0; else req0_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, input string tag);
        int n = 0;
        while (!rsp_valid[k] && n < 40) begin
            @(negedge clk); n++;
        end
        chk({tag, "_rsp_timeout"}, 64'(n < 40), 1);
    endtask

    task automatic op(input int k, input bit id, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] z, input string tag);
        int e0;
        q.push_back('{z: z, id: id});
        drive_req(k, id, a, b);
        accept(k, id, tag, e0);
        wait_rsp(k, tag);
        chk({tag, "_latency"}, 64'(cyc - e0), 64'(lat_of(k) + 1));
        pop_chk(k, tag);
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        chk({tag, "_busy_after"}, busy[k], 0);
        chk({tag, "_valid_after"}, rsp_valid[k], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e0, n, prev, acc, bad_z, bad_id, bad_rdy, bad_busy;
        logic [63:0] hold_z;
        logic        hold_id;
        string       tag;

        reset      = 1'b0;
        req0_valid = '1;
        req1_valid = '1;
        rsp_ready  = '0;
        for (int k = 0; k < 3; k++) begin
            req0_a[k] = '0; req0_b[k] = '0; req1_a[k] = '0; req1_b[k] = '0;
        end

        // Reset values, with both requests asserted to show readys are gated.
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tag = $sformatf("rst%0d", k);
            chk({tag, "_ready0"}, req0_ready[k], 0);
            chk({tag, "_ready1"}, req1_ready[k], 0);
            chk({tag, "_valid"},  rsp_valid[k], 0);
            chk({tag, "_busy"},   busy[k], 0);
            chk({tag, "_z"},      rsp_z[k], 0);
            chk({tag, "_id"},     rsp_id[k], 0);
        end
        req0_valid = '0;
        req1_valid = '0;
        reset      = 1'b1;
        @(negedge clk);

        // Directed sign cases on the MULT_LAT=1 instance.
        op(0, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 64'h0000_0000_0000_0019, "neg");
        op(0, 1, 32'hFFFF_FFFB, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFE7, "mixed");
        op(0, 0, 32'd3, 32'd4, 64'd12, "small");

        // Abort an in-flight req1 operation; the pointer must return to its reset value.
        drive_req(0, 1, 32'd9, 32'd9);
        accept(0, 1, "rstw", e0);
        chk("rstw_in_wait", busy[0], 1);
        reset = 1'b0;
        #1;
        chk("rstw_busy", busy[0], 0);
        chk("rstw_valid", rsp_valid[0], 0);
        req0_valid[0] = 1'b1;
        req1_valid[0] = 1'b1;
        #1;
        chk("rstw_ready_gated", {req0_ready[0], req1_ready[0]}, 2'b00);
        req0_valid[0] = 1'b0;
        req1_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid[0] || busy[0]) n++;
        end
        chk("rstw_no_rsp", 64'(n), 0);
        req0_valid[0] = 1'b1;
        req1_valid[0] = 1'b1;
        #1;
        chk("rstw_tie_grant", {req1_ready[0], req0_ready[0]}, 2'b01);
        req0_valid[0] = 1'b0;
        req1_valid[0] = 1'b0;
        op(0, 0, 32'd10, 32'd5, 64'h32, "post_rst");

        // Contention: both requesters held valid; last served was 0 so 1 goes first.
        rsp_ready[0]  = 1'b1;
        req0_a[0]     = 32'd10;         req0_b[0] = 32'd5;
        req1_a[0]     = 32'hFFFF_FFFB;  req1_b[0] = 32'hFFFF_FFFB;
        req0_valid[0] = 1'b1;
        req1_valid[0] = 1'b1;
        prev = -1;
        acc  = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (rsp_valid[0]) pop_chk(0, "cont");
            if (req0_ready[0] || req1_ready[0]) begin
                chk("cont_one_ready", 64'(req0_ready[0] & req1_ready[0]), 0);
                if (prev < 0) chk("cont_first", req1_ready[0], 1);
                else          chk("cont_alternate", 64'(req1_ready[0]), 64'(prev == 0));
                prev = req1_ready[0] ? 1 : 0;
                q.push_back('{z: req1_ready[0] ? 64'd25 : 64'h32, id: req1_ready[0]});
                acc++;
            end else if (acc >= 6) begin
                break;
            end
            @(negedge clk);
        end
        chk("cont_accepts", 64'(acc), 6);
        req0_valid[0] = 1'b0;
        req1_valid[0] = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk); #1; n++;
            if (rsp_valid[0]) pop_chk(0, "cont_drain");
        end
        chk("cont_drained", 64'(q.size()), 0);
        @(negedge clk);
        rsp_ready[0] = 1'b0;

        // Backpressure: response held while a new request waits.
        q.push_back('{z: 64'hFFFF_FFFF_FFFF_FFEB, id: 1'b1});
        drive_req(0, 1, 32'd7, 32'hFFFF_FFFD);
        accept(0, 1, "bp", e0);
        wait_rsp(0, "bp");
        pop_chk(0, "bp");
        hold_z  = rsp_z[0];
        hold_id = rsp_id[0];
        drive_req(0, 0, 32'd2, 32'd3);
        bad_z = 0; bad_id = 0; bad_rdy = 0; bad_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_z[0] !== hold_z)                    bad_z++;
            if (rsp_id[0] !== hold_id)                  bad_id++;
            if ((req0_ready[0] | req1_ready[0]) !== 1'b0) bad_rdy++;
            if (busy[0] !== 1'b1 || rsp_valid[0] !== 1'b1) bad_busy++;
        end
        chk("bp_z_stable", 64'(bad_z), 0);
        chk("bp_id_stable", 64'(bad_id), 0);
        chk("bp_readys_low", 64'(bad_rdy), 0);
        chk("bp_busy_valid", 64'(bad_busy), 0);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        #1;
        chk("bp_idle_next", busy[0], 0);
        chk("bp_pending_ready", req0_ready[0], 1);
        q.push_back('{z: 64'd6, id: 1'b0});
        @(posedge clk);
        @(negedge clk);
        req0_valid[0] = 1'b0;
        wait_rsp(0, "bp2");
        pop_chk(0, "bp2");
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;

        // Extremes on every latency variant.
        for (int k = 0; k < 3; k++) begin
            op(k, 0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,
               $sformatf("ext_min_lat%0d", lat_of(k)));
            op(k, 1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000,
               $sformatf("ext_mix_lat%0d", lat_of(k)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
